// File: rtl/gru_hidden_update_collector.sv
// GRU hidden-state collector: h_t[idx] = n + z*(h_prev - n) in Q(FRAC_BITS), gathered into a frame buffer.
// Define GRU_HUPD_SAT_EN to saturate the result; otherwise it wraps to DATA_WIDTH bits.
module gru_hidden_update_collector #(
  parameter int H          = 256,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IDX_W      = $clog2(H)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IDX_W-1:0]             in_idx,
  input  logic signed [DATA_WIDTH-1:0] in_n,
  input  logic signed [DATA_WIDTH-1:0] in_z,
  input  logic signed [DATA_WIDTH-1:0] in_h_prev,
  output logic signed [DATA_WIDTH-1:0] h_t [H-1:0],
  output logic                         frame_valid,
  input  logic                         frame_ack,
  output logic                         dup_err,
  output logic                         idx_err
);

  localparam int SW = 2 * DATA_WIDTH + 1;
  localparam int CW = $clog2(H + 1);

  typedef enum logic {COLLECT, FULL} state_t;
  state_t state, state_nxt;

  logic                         accept;
  logic                         s1_valid, s2_valid;
  logic [IDX_W-1:0]             s1_idx, s2_idx;
  logic signed [DATA_WIDTH-1:0] s1_n, s1_z;
  logic signed [DATA_WIDTH:0]   s1_diff, diff_c;
  logic signed [SW-1:0]         prod_c, sum_c, s2_sum;
  logic [DATA_WIDTH-1:0]        result_c;

  logic [H-1:0]  bitmap, sel;
  logic [CW-1:0] count;
  logic          commit_new, commit_dup, commit_bad, last_commit;

  // Stage 1: difference term; stage 2: scaled product plus n
  always_comb begin
    diff_c = {in_h_prev[DATA_WIDTH-1], in_h_prev} - {in_n[DATA_WIDTH-1], in_n};
    prod_c = (SW'(s1_z) * SW'(s1_diff)) >>> FRAC_BITS;
    sum_c  = SW'(s1_n) + prod_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_n     <= '0;
      s1_z     <= '0;
      s1_diff  <= '0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_sum   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx  <= in_idx;
        s1_n    <= in_n;
        s1_z    <= in_z;
        s1_diff <= diff_c;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_sum <= sum_c;
      end
    end
  end

`ifdef GRU_HUPD_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    if (s2_sum > SAT_MAX)      result_c = SAT_MAX[DATA_WIDTH-1:0];
    else if (s2_sum < SAT_MIN) result_c = SAT_MIN[DATA_WIDTH-1:0];
    else                       result_c = s2_sum[DATA_WIDTH-1:0];
  end
`else
  logic sum_unused;
  assign result_c   = s2_sum[DATA_WIDTH-1:0];
  assign sum_unused = ^s2_sum[SW-1:DATA_WIDTH];
`endif

  // One-hot decode of the committing index; an out-of-range index decodes to nothing
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < H; i++)
      sel[i] = s2_valid && (s2_idx == IDX_W'(i));
  end

  always_comb begin
    commit_new  = |(sel & ~bitmap);
    commit_dup  = |(sel & bitmap);
    commit_bad  = s2_valid && !(|sel);
    last_commit = commit_new && (count == CW'(H - 1));
  end

  always_comb begin
    state_nxt   = state;
    frame_valid = 1'b0;
    in_ready    = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = rst_n;
        if (last_commit) state_nxt = FULL;
      end
      FULL: begin
        frame_valid = 1'b1;
        if (frame_ack) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
    accept = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap  <= '0;
      count   <= '0;
      dup_err <= 1'b0;
      idx_err <= 1'b0;
      for (int unsigned i = 0; i < H; i++) h_t[i] <= '0;
    end else begin
      // A beat landing on the ack edge still writes h_t; the bitmap clear wins
      if (state == FULL && frame_ack) begin
        bitmap <= '0;
        count  <= '0;
      end else if (commit_new) begin
        bitmap <= bitmap | sel;
        count  <= count + CW'(1);
      end
      if (commit_dup) dup_err <= 1'b1;
      if (commit_bad) idx_err <= 1'b1;
      for (int unsigned i = 0; i < H; i++)
        if (sel[i]) h_t[i] <= result_c;
    end
  end

endmodule

// File: tb/tb_gru_hidden_update_collector.sv
// Bench for gru_hidden_update_collector with H=4: arithmetic scoreboard model plus directed literal checks.
module tb_gru_hidden_update_collector;

  localparam int H  = 4;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int IW = 3;

`ifdef GRU_HUPD_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h7E00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, frame_valid, frame_ack, dup_err, idx_err;
  logic [IW-1:0]        in_idx;
  logic signed [DW-1:0] in_n, in_z, in_h_prev;
  logic signed [DW-1:0] h_t [H-1:0];

  gru_hidden_update_collector #(
    .H(H), .DATA_WIDTH(DW), .FRAC_BITS(FB), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_n(in_n), .in_z(in_z), .in_h_prev(in_h_prev),
    .h_t(h_t), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .dup_err(dup_err), .idx_err(idx_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: n + floor(z*(h_prev-n)/2^8), then saturate or wrap to 16 bits
  function automatic logic [15:0] gru_ref(input logic [15:0] n, input logic [15:0] z,
                                          input logic [15:0] hp);
    longint ln, lz, lh, q, fl, s;
    logic [63:0] u;
    ln = longint'($signed(n));
    lz = longint'($signed(z));
    lh = longint'($signed(hp));
    q  = lz * (lh - ln);
    fl = q / 256;
    if (q < 0 && (q % 256) != 0) fl = fl - 1;
    s = ln + fl;
`ifdef GRU_HUPD_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    u = s;
    return u[15:0];
  endfunction

  // Scoreboard: accepted beats queue up and land two edges later
  logic [15:0] m_h [H];
  bit          m_seen [H];
  int          m_cnt;
  bit          m_full, m_dup, m_ierr;
  bit          p1_v, p2_v;
  int          p1_i, p2_i;
  logic [15:0] p1_d, p2_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) begin
        m_h[i]    = '0;
        m_seen[i] = 0;
      end
      m_cnt = 0; m_full = 0; m_dup = 0; m_ierr = 0;
      p1_v = 0; p2_v = 0; p1_i = 0; p2_i = 0; p1_d = '0; p2_d = '0;
    end else begin
      bit ack_now, acc;
      ack_now = m_full && frame_ack;
      acc     = in_valid && !m_full;
      if (p2_v) begin
        if (p2_i >= H) m_ierr = 1;
        else begin
          m_h[p2_i] = p2_d;
          if (m_seen[p2_i]) m_dup = 1;
          else begin
            m_seen[p2_i] = 1;
            m_cnt++;
            if (m_cnt == H) m_full = 1;
          end
        end
      end
      if (ack_now) begin
        m_full = 0;
        m_cnt  = 0;
        for (int i = 0; i < H; i++) m_seen[i] = 0;
      end
      p2_v = p1_v; p2_i = p1_i; p2_d = p1_d;
      p1_v = acc;
      p1_i = int'(in_idx);
      p1_d = gru_ref(in_n, in_z, in_h_prev);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < H; i++) chk($sformatf("model_h_t[%0d]", i), h_t[i][15:0], m_h[i]);
      chk("model_frame_valid", {15'd0, frame_valid}, {15'd0, m_full});
      chk("model_in_ready", {15'd0, in_ready}, {15'd0, !m_full});
      chk("model_dup_err", {15'd0, dup_err}, {15'd0, m_dup});
      chk("model_idx_err", {15'd0, idx_err}, {15'd0, m_ierr});
    end
  end

  task automatic beat(input int i, input logic [15:0] n, input logic [15:0] z, input logic [15:0] hp);
    in_valid  = 1'b1;
    in_idx    = IW'(i);
    in_n      = n;
    in_z      = z;
    in_h_prev = hp;
    @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] n, input logic [15:0] z, input logic [15:0] hp);
    for (int i = 0; i < H; i++) beat(i, n, z, hp);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_fv_low", {15'd0, frame_valid}, 16'd0);
    chk("ack_ready_high", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic chk_all_h(input string nm, input logic [15:0] exp);
    for (int i = 0; i < H; i++) chk($sformatf("%s[%0d]", nm, i), h_t[i][15:0], exp);
  endtask

  task automatic chk_reset(input string nm);
    chk_all_h({nm, "_h_t"}, 16'h0000);
    chk({nm, "_fv"}, {15'd0, frame_valid}, 16'd0);
    chk({nm, "_ready"}, {15'd0, in_ready}, 16'd0);
    chk({nm, "_dup"}, {15'd0, dup_err}, 16'd0);
    chk({nm, "_idx"}, {15'd0, idx_err}, 16'd0);
  endtask

  initial begin
    in_valid = 1'b0; in_idx = '0; in_n = '0; in_z = '0; in_h_prev = '0; frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: latency from 4th accept to frame_valid is two edges
    for (int i = 0; i < H; i++) beat(i, 16'h0100, 16'h0080, 16'h0000);
    in_valid = 1'b0;
    chk("t1_fv_at_accept", {15'd0, frame_valid}, 16'd0);
    @(negedge clk);
    chk("t1_fv_plus1", {15'd0, frame_valid}, 16'd0);
    @(negedge clk);
    chk("t1_fv_plus2", {15'd0, frame_valid}, 16'd1);
    chk("t1_ready_full", {15'd0, in_ready}, 16'd0);
    chk_all_h("t1_h_t", 16'h0080);
    ack();

    // Pass-through with z = 1.0
    frame(16'h0040, 16'h0100, 16'h0200);
    chk("t2_fv", {15'd0, frame_valid}, 16'd1);
    chk_all_h("t2_h_t", 16'h0200);
    ack();

    // Overflow of n + z*(hp-n)
    frame(16'h7F00, 16'hFF00, 16'h8000);
    chk("t3_fv", {15'd0, frame_valid}, 16'd1);
    chk_all_h("t3_h_t", OVF_EXP);
    ack();

    // Duplicate index and out-of-range index
    beat(2, 16'h0100, 16'h0080, 16'h0000);
    beat(2, 16'h0200, 16'h0000, 16'h0000);
    beat(5, 16'h1234, 16'h0000, 16'h0000);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_h_t2", h_t[2][15:0], 16'h0200);
    chk("t4_dup", {15'd0, dup_err}, 16'd1);
    chk("t4_idx", {15'd0, idx_err}, 16'd1);
    chk("t4_fv_partial", {15'd0, frame_valid}, 16'd0);
    beat(0, 16'h0300, 16'h0000, 16'h0000);
    beat(1, 16'h0300, 16'h0000, 16'h0000);
    chk("t4_fv_3of4", {15'd0, frame_valid}, 16'd0);
    beat(3, 16'h0300, 16'h0000, 16'h0000);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_fv_done", {15'd0, frame_valid}, 16'd1);

    // Held in_valid while FULL must not be accepted
    in_valid = 1'b1; in_idx = '0; in_n = 16'h0100; in_z = 16'h0000; in_h_prev = 16'h0000;
    repeat (3) @(negedge clk);
    chk("t5_ready_full", {15'd0, in_ready}, 16'd0);
    chk("t5_h0_hold", h_t[0][15:0], 16'h0300);
    frame_ack = 1'b1;
    @(negedge clk);
    chk("t5_fv_after_ack", {15'd0, frame_valid}, 16'd0);
    chk("t5_ready_after_ack", {15'd0, in_ready}, 16'd1);
    chk("t5_h0_after_ack", h_t[0][15:0], 16'h0300);
    chk("t5_h2_after_ack", h_t[2][15:0], 16'h0200);
    frame_ack = 1'b0;
    in_valid  = 1'b0;
    frame(16'h0100, 16'h0080, 16'h0040);
    chk("t5_fv", {15'd0, frame_valid}, 16'd1);
    chk_all_h("t5_h_t", 16'h00A0);
    ack();

    // Asynchronous reset mid-frame
    beat(0, 16'h0100, 16'h0080, 16'h0000);
    beat(1, 16'h0100, 16'h0080, 16'h0000);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'h0000, 16'h0001, 16'hFFFF);
    chk("t6_fv", {15'd0, frame_valid}, 16'd1);
    chk_all_h("t6_h_t", 16'hFFFF);
    chk("t6_dup", {15'd0, dup_err}, 16'd0);
    chk("t6_idx", {15'd0, idx_err}, 16'd0);
    ack();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
